pc_fetch: RTL and testbench

- Program counter and operand-fetch stage; sits directly upstream of the control unit.
- Drives the program-memory address, advances on the control unit's `pcc` strobe, and handles jumps.
- A jump fetches a two-byte absolute target (high byte first) from the bytes following the opcode, then loads it if the condition holds.
- Also provides call/return via a small hardware return-address stack.

---
 rtl/pc_fetch.sv | 155 +++++++++++++++
 tb/tb_pc_fetch.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Program counter and jump-operand fetch stage.
// Handles pcc increments, two-byte absolute jumps, call/return stack.
module pc_fetch #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcc,
  input  logic        jmp,
  input  logic [2:0]  cond,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        flag_n,
  input  logic        flag_v,
  input  logic        ret,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] pc_addr,
  output logic        busy,
  output logic        taken,
  output logic        stk_err,
  output logic [3:0]  stk_level
);

  localparam int AW =
    (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [3:0] DEPTH = 4'(STACK_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n, pc_inc;
  logic [2:0]  cond_q;
  logic [3:0]  flg_q;
  logic [7:0]  hi_q;
  logic [15:0] stk [STACK_DEPTH];
  logic [3:0]  lvl;
  logic        taken_q, err_q;
  logic        hit, full, empty;
  logic        push, pop, load;
  logic        err_set, cap, hi_ld;
  logic [AW-1:0] wr_idx, rd_idx;

  assign pc_inc = pc + 16'd1;
  assign full   = (lvl == DEPTH);
  assign empty  = (lvl == 4'd0);
  assign wr_idx = lvl[AW-1:0];
  assign rd_idx = AW'(lvl - 4'd1);

  // flg_q = {z, c, n, v}, frozen on the jmp cycle
  always_comb begin
    hit = 1'b1;
    unique case (cond_q)
      3'd0: hit = 1'b1;
      3'd1: hit = flg_q[3];
      3'd2: hit = !flg_q[3];
      3'd3: hit = flg_q[2];
      3'd4: hit = !flg_q[2];
      3'd5: hit = flg_q[1];
      3'd6: hit = flg_q[0];
      3'd7: hit = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
    err_set = 1'b0;
    cap     = 1'b0;
    hi_ld   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ret) begin
          if (!empty) begin
            pc_n = stk[rd_idx];
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            pc_n    = pc_inc;
            err_set = 1'b1;
          end
        end else if (jmp) begin
          cap     = 1'b1;
          pc_n    = pc_inc;
          state_n = HI;
        end else if (pcc) begin
          pc_n = pc_inc;
        end
      end
      HI: begin
        hi_ld   = 1'b1;
        pc_n    = pc_inc;
        state_n = LO;
      end
      LO: begin
        state_n = IDLE;
        if (hit) begin
          pc_n = {hi_q, mem_rdata};
          load = 1'b1;
          // a call on a full stack still jumps
          if (cond_q == 3'd7) begin
            if (full) err_set = 1'b1;
            else      push    = 1'b1;
          end
        end else begin
          pc_n = pc_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      cond_q  <= 3'd0;
      flg_q   <= 4'd0;
      hi_q    <= 8'd0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      lvl     <= 4'd0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      taken_q <= load;
      if (err_set) err_q <= 1'b1;
      if (cap) begin
        cond_q <= cond;
        flg_q  <= {flag_z, flag_c, flag_n, flag_v};
      end
      if (hi_ld) hi_q <= mem_rdata;
      if (push)     lvl <= lvl + 4'd1;
      else if (pop) lvl <= lvl - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk[wr_idx] <= pc_inc;
  end

  assign pc_addr   = pc;
  assign busy      = (state != IDLE);
  assign taken     = taken_q;
  assign stk_err   = err_q;
  assign stk_level = lvl;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed steps then
// random strobes against a transaction-level reference model.
module tb_pc_fetch;

  localparam logic [15:0] RPC   = 16'h0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcc, jmp, ret;
  logic [2:0]  cond;
  logic        flag_z, flag_c, flag_n, flag_v;
  logic [7:0]  mem_rdata;
  logic [15:0] pc_addr;
  logic        busy, taken, stk_err;
  logic [3:0]  stk_level;

  logic [7:0] mem [65536];
  assign mem_rdata = mem[pc_addr];

  pc_fetch #(
    .RESET_PC    (RPC),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pcc       (pcc),
    .jmp       (jmp),
    .cond      (cond),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .ret       (ret),
    .mem_rdata (mem_rdata),
    .pc_addr   (pc_addr),
    .busy      (busy),
    .taken     (taken),
    .stk_err   (stk_err),
    .stk_level (stk_level)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: a jump is resolved whole when accepted,
  // then revealed after two more cycles
  logic [15:0] m_pc;
  logic [15:0] m_q [$];
  logic        m_err;
  logic        m_taken;
  int          m_left;
  logic [15:0] m_fin_pc;
  logic [15:0] m_ret_addr;
  logic        m_fin_take;
  logic        m_fin_call;

  function automatic logic cond_ok(
    input logic [2:0] c,
    input logic z, cy, n, v
  );
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      3'd5: return n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(
    input string tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all;
    chk("pc_addr", pc_addr, m_pc);
    chk("busy", 16'(busy), 16'(m_left > 0));
    chk("taken", 16'(taken), 16'(m_taken));
    chk("stk_err", 16'(stk_err), 16'(m_err));
    chk("stk_level", 16'(stk_level), 16'(m_q.size()));
  endtask

  task automatic m_reset;
    m_pc    = RPC;
    m_q.delete();
    m_err   = 1'b0;
    m_taken = 1'b0;
    m_left  = 0;
  endtask

  task automatic model_edge;
    logic [15:0] a1, a2;
    m_taken = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_pc = m_fin_pc;
        if (m_fin_take) begin
          m_taken = 1'b1;
          if (m_fin_call) begin
            if (m_q.size() == DEPTH) m_err = 1'b1;
            else m_q.push_back(m_ret_addr);
          end
        end
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end else if (ret) begin
      if (m_q.size() > 0) begin
        m_pc    = m_q.pop_back();
        m_taken = 1'b1;
      end else begin
        m_pc  = m_pc + 16'd1;
        m_err = 1'b1;
      end
    end else if (jmp) begin
      a1 = m_pc + 16'd1;
      a2 = m_pc + 16'd2;
      m_ret_addr = m_pc + 16'd3;
      m_fin_take = cond_ok(cond, flag_z, flag_c,
                           flag_n, flag_v);
      m_fin_call = (cond == 3'd7);
      m_fin_pc   = m_fin_take ? {mem[a1], mem[a2]}
                              : m_ret_addr;
      m_pc   = a1;
      m_left = 2;
    end else if (pcc) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    model_edge();
    chk_all();
    pcc = 1'b0;
    jmp = 1'b0;
    ret = 1'b0;
  endtask

  task automatic do_pcc(input int n);
    repeat (n) begin
      pcc = 1'b1;
      tick();
    end
  endtask

  task automatic set_ops(
    input logic [15:0] at,
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    logic [15:0] a1, a2;
    a1 = at + 16'd1;
    a2 = at + 16'd2;
    mem[a1] = hi;
    mem[a2] = lo;
  endtask

  // flags are inverted during HI/LO to prove they were latched
  task automatic do_jmp(
    input logic [2:0] c,
    input logic z, cy, n, v
  );
    cond   = c;
    flag_z = z;
    flag_c = cy;
    flag_n = n;
    flag_v = v;
    jmp    = 1'b1;
    tick();
    flag_z = !z;
    flag_c = !cy;
    flag_n = !n;
    flag_v = !v;
    tick();
    tick();
  endtask

  task automatic goto(input logic [15:0] t);
    set_ops(m_pc, t[15:8], t[7:0]);
    do_jmp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_ret;
    ret = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++)
      mem[i] = 8'($urandom);
    reset  = 1'b1;
    pcc    = 1'b0;
    jmp    = 1'b0;
    ret    = 1'b0;
    cond   = 3'd0;
    flag_z = 1'b0;
    flag_c = 1'b0;
    flag_n = 1'b0;
    flag_v = 1'b0;
    #3;
    m_reset();
    chk_all();
    @(negedge clk);
    reset = 1'b0;

    do_pcc(5);
    chk("pcc_five", pc_addr, 16'h0005);

    do_pcc(11);
    mem[16'h0011] = 8'h12;
    mem[16'h0012] = 8'h34;
    do_jmp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jmp_always_pc", pc_addr, 16'h1234);
    chk("jmp_always_tk", 16'(taken), 16'h1);
    tick();

    goto(16'h0010);
    do_jmp(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jmp_z_untaken", pc_addr, 16'h0013);
    chk("untaken_no_tk", 16'(taken), 16'h0);

    goto(16'h0100);
    set_ops(16'h0100, 8'h20, 8'h00);
    do_jmp(3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("call_pc", pc_addr, 16'h2000);
    chk("call_lvl", 16'(stk_level), 16'h1);
    do_ret();
    chk("ret_pc", pc_addr, 16'h0103);
    chk("ret_lvl", 16'(stk_level), 16'h0);
    chk("ret_tk", 16'(taken), 16'h1);

    for (int i = 0; i < 5; i++) begin
      set_ops(m_pc, 8'(8'h30 + i), 8'h00);
      do_jmp(3'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    end
    chk("ovf_err", 16'(stk_err), 16'h1);
    chk("ovf_lvl", 16'(stk_level), 16'h4);
    chk("ovf_pc", pc_addr, 16'h3400);
    repeat (4) do_ret();
    chk("lifo_last", pc_addr, 16'h0106);
    do_ret();
    chk("unf_pc", pc_addr, 16'h0107);
    chk("unf_err", 16'(stk_err), 16'h1);

    goto(16'hFFFF);
    do_pcc(1);
    chk("wrap_pcc", pc_addr, 16'h0000);
    goto(16'hFFFE);
    set_ops(16'hFFFE, 8'h45, 8'h67);
    do_jmp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_ops", pc_addr, 16'h4567);

    set_ops(m_pc, 8'h50, 8'h00);
    do_jmp(3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cond = 3'd0;
    jmp  = 1'b1;
    ret  = 1'b1;
    pcc  = 1'b1;
    tick();
    chk("ret_wins_pc", pc_addr, 16'h456A);
    chk("ret_wins_busy", 16'(busy), 16'h0);

    cond = 3'd0;
    jmp  = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    chk_all();
    chk("rst_hi_busy", 16'(busy), 16'h0);
    chk("rst_hi_pc", pc_addr, RPC);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      cond   = 3'($urandom);
      flag_z = 1'($urandom);
      flag_c = 1'($urandom);
      flag_n = 1'($urandom);
      flag_v = 1'($urandom);
      pcc    = 1'($urandom);
      jmp    = ($urandom_range(0, 3) == 0);
      ret    = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
